// File: rtl/dmem_arbiter_pkg.sv
// Shared types and default widths for the data-memory arbiter.
package dmem_arbiter_pkg;

    localparam int unsigned DefNumCores = 4;
    localparam int unsigned DefAddrW    = 16;
    localparam int unsigned DefDataW    = 16;
    localparam int unsigned GrantW      = 2;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StAck   = 2'd2
    } state_e;

endpackage

// File: rtl/dmem_arbiter_rr_select.sv
// Round-robin selector: first set request bit searching upward from last_grant+1.
module rr_select
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned NUM_CORES = DefNumCores
) (
    input  logic [NUM_CORES-1:0] req,
    input  logic [GrantW-1:0]    last_grant,
    output logic [GrantW-1:0]    winner,
    output logic                 valid
);

    logic [GrantW-1:0] idx;

    always_comb begin
        winner = '0;
        valid  = 1'b0;
        idx    = '0;
        for (int unsigned i = 1; i <= NUM_CORES; i++) begin
            idx = GrantW'((32'(last_grant) + i) % NUM_CORES);
            if (!valid && req[idx]) begin
                valid  = 1'b1;
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter: round-robin among cores, three-cycle access,
// with a testbench back door that owns the memory port while the FSM is idle.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned NUM_CORES = DefNumCores,
    parameter int unsigned ADDR_W    = DefAddrW,
    parameter int unsigned DATA_W    = DefDataW
) (
    input  logic                        clk,
    input  logic                        RESET,
    input  logic [NUM_CORES-1:0]        req,
    input  logic [NUM_CORES-1:0]        we,
    input  logic [NUM_CORES*ADDR_W-1:0] addr_flat,
    input  logic [NUM_CORES*DATA_W-1:0] wdata_flat,
    output logic [NUM_CORES-1:0]        ack,
    output logic [DATA_W-1:0]           rdata,
    input  logic                        tb_sel,
    input  logic                        tb_we,
    input  logic [ADDR_W-1:0]           tb_addr,
    input  logic [DATA_W-1:0]           tb_wdata,
    output logic                        mem_we,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_wdata,
    input  logic [DATA_W-1:0]           mem_rdata,
    output logic                        busy,
    output logic [GrantW-1:0]           grant_id
);

    state_e              state_q, state_d;
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   rdata_q;
    logic [GrantW-1:0]   grant_q;
    logic [GrantW-1:0]   last_grant_q;
    logic [GrantW-1:0]   winner;
    logic                win_valid;
    logic                start;

    logic [ADDR_W-1:0]   addr_arr  [NUM_CORES];
    logic [DATA_W-1:0]   wdata_arr [NUM_CORES];

    for (genvar g = 0; g < NUM_CORES; g++) begin : g_unpack
        assign addr_arr[g]  = addr_flat[g*ADDR_W +: ADDR_W];
        assign wdata_arr[g] = wdata_flat[g*DATA_W +: DATA_W];
    end

    rr_select #(
        .NUM_CORES (NUM_CORES)
    ) u_rr_select (
        .req        (req),
        .last_grant (last_grant_q),
        .winner     (winner),
        .valid      (win_valid)
    );

    // The back door blocks new grants only while the FSM is idle.
    assign start = (state_q == StIdle) && !tb_sel && win_valid;

    always_ff @(posedge clk) begin
        if (!RESET) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StIssue;
            StIssue: state_d = StAck;
            StAck:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        ack       = '0;
        mem_we    = 1'b0;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        unique case (state_q)
            StIdle: begin
                if (tb_sel) begin
                    mem_we    = tb_we;
                    mem_addr  = tb_addr;
                    mem_wdata = tb_wdata;
                end
            end
            StIssue: mem_we       = we_q;
            StAck:   ack[grant_q] = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!RESET) begin
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            grant_q      <= '0;
            last_grant_q <= GrantW'(NUM_CORES - 1);
        end else begin
            if (start) begin
                we_q    <= we[winner];
                addr_q  <= addr_arr[winner];
                wdata_q <= wdata_arr[winner];
                grant_q <= winner;
            end
            // Writes return their own data so rdata is meaningful on every ack.
            if (state_q == StIssue) begin
                rdata_q <= we_q ? wdata_q : mem_rdata;
            end
            if (state_q == StAck) begin
                last_grant_q <= grant_q;
            end
        end
    end

    assign rdata    = rdata_q;
    assign busy     = (state_q != StIdle);
    assign grant_id = grant_q;

endmodule
